// File: rtl/ts_rx_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ts_rx_chk_pkg
// Brief   : Symbol constants, TS type and checker state encodings.
// Revision: 1.0
// ============================================================================
package ts_rx_chk_pkg;

    localparam logic [7:0] C_COM    = 8'hBC;
    localparam logic [7:0] C_PADG12 = 8'hF7;
    localparam logic [7:0] C_D10_2  = 8'h4A;
    localparam logic [7:0] C_D5_2   = 8'h45;
    localparam logic [7:0] C_D21_5  = 8'hB5;
    localparam logic [7:0] C_D26_5  = 8'hBA;

    typedef enum logic [1:0] {
        TS_NONE = 2'd0,
        TS_1    = 2'd1,
        TS_2    = 2'd2
    } ts_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_TRACK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Symbol 0 sits in the most significant byte.
    function automatic logic [7:0] get_sym(input logic [127:0] os, input int idx);
        return os[127 - 8*idx -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_rx_chk_if.sv
`default_nettype none
// ============================================================================
// Module  : ts_rx_chk_if
// Brief   : RX FIFO read port between the FIFO (slave) and the checker (master).
// Revision: 1.0
// ============================================================================
interface ts_rx_chk_if;

    logic         rx_fifo_empty;
    logic         rx_fifo_rd;
    logic [127:0] rx_fifo_data;

    modport master (
        output rx_fifo_rd,
        input  rx_fifo_empty,
        input  rx_fifo_data
    );

    modport slave (
        input  rx_fifo_rd,
        output rx_fifo_empty,
        output rx_fifo_data
    );

endinterface
`default_nettype wire

// File: rtl/ts_rx_decode.sv
`default_nettype none
// ============================================================================
// Module  : ts_rx_decode
// Brief   : Combinational TS1/TS2 classifier and field splitter.
//           Macro TS_RX_POLARITY_DET_EN adds inverted-polarity identifiers.
// Revision: 1.0
// ============================================================================
module ts_rx_decode
    import ts_rx_chk_pkg::*;
(
    input  wire logic [127:0] os,
    output ts_type_e          ts_type,
    output logic              malformed,
`ifdef TS_RX_POLARITY_DET_EN
    output logic              inverted,
`endif
    output logic [39:0]       id_syms,
    output logic [7:0]        link_num,
    output logic [7:0]        lane_num,
    output logic [5:0]        rate
);

    logic w_all_d10;
    logic w_all_d5;
    logic w_all_d21;
    logic w_all_d26;

    always_comb begin
        w_all_d10 = 1'b1;
        w_all_d5  = 1'b1;
        w_all_d21 = 1'b1;
        w_all_d26 = 1'b1;
        for (int i = 6; i < 16; i++) begin
            w_all_d10 &= (get_sym(os, i) == C_D10_2);
            w_all_d5  &= (get_sym(os, i) == C_D5_2);
            w_all_d21 &= (get_sym(os, i) == C_D21_5);
            w_all_d26 &= (get_sym(os, i) == C_D26_5);
        end
    end

    always_comb begin
        ts_type = TS_NONE;
`ifdef TS_RX_POLARITY_DET_EN
        inverted = 1'b0;
`endif
        if (get_sym(os, 0) == C_COM) begin
            if (w_all_d10) begin
                ts_type = TS_1;
            end else if (w_all_d5) begin
                ts_type = TS_2;
`ifdef TS_RX_POLARITY_DET_EN
            end else if (w_all_d21) begin
                ts_type  = TS_1;
                inverted = 1'b1;
            end else if (w_all_d26) begin
                ts_type  = TS_2;
                inverted = 1'b1;
`endif
            end
        end
        malformed = (ts_type == TS_NONE);
    end

    assign id_syms  = os[119:80];
    assign link_num = get_sym(os, 1);
    assign lane_num = get_sym(os, 2);
    assign rate     = os[93:88];

`ifndef TS_RX_POLARITY_DET_EN
    // Inverted identifiers are simply malformed in this build.
    logic w_unused_inv;
    assign w_unused_inv = w_all_d21 | w_all_d26;
`endif

endmodule
`default_nettype wire

// File: rtl/ts_rx_chk.sv
`default_nettype none
// ============================================================================
// Module  : ts_rx_chk
// Brief   : RX TS1/TS2 checker: pops ordered sets, counts consecutive
//           identical sets and flags the LTSSM. Optional TS_RX_POLARITY_DET_EN.
// Revision: 1.0
// ============================================================================
module ts_rx_chk
    import ts_rx_chk_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter bit SAT_EN_DEFAULT = 1'b1
)
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             rx_en,
    input  wire logic             rx_clear,
    input  wire logic [CNT_W-1:0] rx_target,
    ts_rx_chk_if.master           fifo,
    output logic                  ts1_rcvd_enough,
    output logic                  ts2_rcvd_enough,
    output logic [CNT_W-1:0]      rx_cnt,
    output logic [7:0]            rx_link_num,
    output logic [7:0]            rx_lane_num,
    output logic [5:0]            rx_rate,
    output logic                  rx_err
`ifdef TS_RX_POLARITY_DET_EN
    ,
    output logic                  rx_pol_inv
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_e           r_state,    w_state_nxt;
    logic             r_rd_d;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic             r_ts1,      w_ts1_nxt;
    logic             r_ts2,      w_ts2_nxt;
    logic             r_err,      w_err_nxt;
    logic [7:0]       r_link,     w_link_nxt;
    logic [7:0]       r_lane,     w_lane_nxt;
    logic [5:0]       r_rate,     w_rate_nxt;
    ts_type_e         r_ref_type, w_ref_type_nxt;
    logic [39:0]      r_ref_id,   w_ref_id_nxt;
`ifdef TS_RX_POLARITY_DET_EN
    logic             r_pol,      w_pol_nxt;
    logic             w_inverted;
`endif

    ts_type_e         w_type;
    logic             w_malformed;
    logic [39:0]      w_id;
    logic [7:0]       w_link;
    logic [7:0]       w_lane;
    logic [5:0]       w_rate;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_inc;

    ts_rx_decode u_decode (
        .os        (fifo.rx_fifo_data),
        .ts_type   (w_type),
        .malformed (w_malformed),
`ifdef TS_RX_POLARITY_DET_EN
        .inverted  (w_inverted),
`endif
        .id_syms   (w_id),
        .link_num  (w_link),
        .lane_num  (w_lane),
        .rate      (w_rate)
    );

    assign fifo.rx_fifo_rd = rx_en & ~fifo.rx_fifo_empty & (r_state != ST_IDLE);

    assign w_same    = (w_type == r_ref_type) && (w_id == r_ref_id);
    assign w_cnt_inc = (&r_cnt) ? (SAT_EN_DEFAULT ? r_cnt : '0) : r_cnt + C_CNT_ONE;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ts1_nxt      = r_ts1;
        w_ts2_nxt      = r_ts2;
        w_err_nxt      = 1'b0;
        w_link_nxt     = r_link;
        w_lane_nxt     = r_lane;
        w_rate_nxt     = r_rate;
        w_ref_type_nxt = r_ref_type;
        w_ref_id_nxt   = r_ref_id;
`ifdef TS_RX_POLARITY_DET_EN
        w_pol_nxt      = r_pol;
`endif
        if (!rx_en || rx_clear) begin
            // Disable and clear share the cleanup; in-flight data is dropped.
            w_state_nxt = rx_en ? ST_HUNT : ST_IDLE;
            w_cnt_nxt   = '0;
            w_ts1_nxt   = 1'b0;
            w_ts2_nxt   = 1'b0;
`ifdef TS_RX_POLARITY_DET_EN
            w_pol_nxt   = 1'b0;
`endif
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_HUNT;
        end else if (r_rd_d) begin
            if (w_malformed) begin
                w_err_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_HUNT;
            end else begin
                w_link_nxt     = w_link;
                w_lane_nxt     = w_lane;
                w_rate_nxt     = w_rate;
                w_ref_type_nxt = w_type;
                w_ref_id_nxt   = w_id;
`ifdef TS_RX_POLARITY_DET_EN
                if (w_inverted) begin
                    w_pol_nxt = 1'b1;
                end
`endif
                if (r_state != ST_HUNT && w_same) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_cnt_nxt = C_CNT_ONE;
                end
                // A zero target is met by the very first valid set.
                if (r_state != ST_DONE && w_cnt_nxt >= rx_target) begin
                    if (w_type == TS_1) begin
                        w_ts1_nxt = 1'b1;
                    end else begin
                        w_ts2_nxt = 1'b1;
                    end
                    w_state_nxt = ST_DONE;
                end else if (r_state == ST_HUNT) begin
                    w_state_nxt = ST_TRACK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd_d     <= 1'b0;
            r_cnt      <= '0;
            r_ts1      <= 1'b0;
            r_ts2      <= 1'b0;
            r_err      <= 1'b0;
            r_link     <= '0;
            r_lane     <= '0;
            r_rate     <= '0;
            r_ref_type <= TS_NONE;
            r_ref_id   <= '0;
`ifdef TS_RX_POLARITY_DET_EN
            r_pol      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rd_d     <= fifo.rx_fifo_rd;
            r_cnt      <= w_cnt_nxt;
            r_ts1      <= w_ts1_nxt;
            r_ts2      <= w_ts2_nxt;
            r_err      <= w_err_nxt;
            r_link     <= w_link_nxt;
            r_lane     <= w_lane_nxt;
            r_rate     <= w_rate_nxt;
            r_ref_type <= w_ref_type_nxt;
            r_ref_id   <= w_ref_id_nxt;
`ifdef TS_RX_POLARITY_DET_EN
            r_pol      <= w_pol_nxt;
`endif
        end
    end

    assign ts1_rcvd_enough = r_ts1;
    assign ts2_rcvd_enough = r_ts2;
    assign rx_cnt          = r_cnt;
    assign rx_link_num     = r_link;
    assign rx_lane_num     = r_lane;
    assign rx_rate         = r_rate;
    assign rx_err          = r_err;
`ifdef TS_RX_POLARITY_DET_EN
    assign rx_pol_inv      = r_pol;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ts_rx_chk.sv
`default_nettype none
// ============================================================================
// Module  : tb_ts_rx_chk
// Brief   : Scoreboard bench for ts_rx_chk with a queue-backed RX FIFO model.
// Revision: 1.0
// ============================================================================
module tb_ts_rx_chk;

    typedef struct {
        logic [15:0] cnt;
        logic        f1;
        logic        f2;
        logic        er;
        logic [7:0]  link;
        logic [5:0]  rate;
        logic        pol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_en = 1'b0;
    logic        rx_clear = 1'b0;
    logic [15:0] rx_target = 16'd8;
    logic        ts1_rcvd_enough;
    logic        ts2_rcvd_enough;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_link_num;
    logic [7:0]  rx_lane_num;
    logic [5:0]  rx_rate;
    logic        rx_err;
    logic        rx_pol_inv;

    int total = 0;
    int bad   = 0;

    logic [127:0] fifo_q[$];
    exp_t         exp_q[$];
    logic [127:0] pend = '0;
    bit           pipe1 = 1'b0;
    bit           pipe2 = 1'b0;
    bit           stall = 1'b0;
    bit           toggle_mode = 1'b0;

    ts_rx_chk_if fif ();

    ts_rx_chk #(.CNT_W(16), .SAT_EN_DEFAULT(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_en           (rx_en),
        .rx_clear        (rx_clear),
        .rx_target       (rx_target),
        .fifo            (fif),
        .ts1_rcvd_enough (ts1_rcvd_enough),
        .ts2_rcvd_enough (ts2_rcvd_enough),
        .rx_cnt          (rx_cnt),
        .rx_link_num     (rx_link_num),
        .rx_lane_num     (rx_lane_num),
        .rx_rate         (rx_rate),
        .rx_err          (rx_err)
`ifdef TS_RX_POLARITY_DET_EN
        ,
        .rx_pol_inv      (rx_pol_inv)
`endif
    );

`ifndef TS_RX_POLARITY_DET_EN
    initial rx_pol_inv = 1'b0;
`endif

    always #5 clk = ~clk;

    // FIFO model: pop decided at the edge, data presented half a cycle later.
    always @(posedge clk) begin
        pipe2 = pipe1;
        pipe1 = fif.rx_fifo_rd;
        if (pipe1) begin
            total++;
            if (fif.rx_fifo_empty || fifo_q.size() == 0) begin
                bad++;
                $display("FAIL rd_when_empty: rd=1 empty=%b queued=%0d, want no rd", fif.rx_fifo_empty, fifo_q.size());
            end
            if (fifo_q.size() != 0) pend = fifo_q.pop_front();
        end
    end

    always @(negedge clk) begin
        if (pipe1) fif.rx_fifo_data = pend;
        if (toggle_mode) stall = ~stall;
        fif.rx_fifo_empty = (fifo_q.size() == 0) || stall;
    end

    // Monitor: one expectation per set whose result lands at this edge.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (pipe2) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_update: cnt=%0d with no expectation queued", rx_cnt);
            end else begin
                e  = exp_q.pop_front();
                ok = (rx_cnt === e.cnt) && (ts1_rcvd_enough === e.f1) && (ts2_rcvd_enough === e.f2) &&
                     (rx_err === e.er) && (rx_link_num === e.link) && (rx_rate === e.rate);
`ifdef TS_RX_POLARITY_DET_EN
                ok = ok && (rx_pol_inv === e.pol);
`endif
                if (!ok) begin
                    bad++;
                    $display("FAIL set_result: got cnt=%0d f1=%b f2=%b err=%b link=%h rate=%h pol=%b want cnt=%0d f1=%b f2=%b err=%b link=%h rate=%h pol=%b",
                             rx_cnt, ts1_rcvd_enough, ts2_rcvd_enough, rx_err, rx_link_num, rx_rate, rx_pol_inv,
                             e.cnt, e.f1, e.f2, e.er, e.link, e.rate, e.pol);
                end
            end
        end else if (!rst) begin
            total++;
            if (rx_err !== 1'b0) begin
                bad++;
                $display("FAIL err_idle: got rx_err=%b want 0", rx_err);
            end
        end
    end

    function automatic logic [127:0] mk(input logic [7:0] s0, input logic [7:0] link, input logic [7:0] lane,
                                        input logic [5:0] rate, input logic [7:0] id);
        logic [127:0] v;
        v = {s0, link, lane, 8'h10, {2'b00, rate}, 8'h00, {10{id}}};
        return v;
    endfunction

    task automatic send(input logic [127:0] d, input int cnt, input logic f1, input logic f2, input logic er,
                        input logic [7:0] link, input logic [5:0] rate, input logic pol);
        exp_t e;
        e.cnt = 16'(cnt); e.f1 = f1; e.f2 = f2; e.er = er; e.link = link; e.rate = rate; e.pol = pol;
        exp_q.push_back(e);
        fifo_q.push_back(d);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL drain_timeout: %0d sets and %0d results outstanding, want 0", fifo_q.size(), exp_q.size());
            fifo_q.delete();
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear();
        rx_clear = 1'b1;
        @(negedge clk);
        rx_clear = 1'b0;
        chk("clear_cnt", 32'(rx_cnt), 32'd0);
        chk("clear_flags", {30'd0, ts1_rcvd_enough, ts2_rcvd_enough}, 32'd0);
`ifdef TS_RX_POLARITY_DET_EN
        chk("clear_pol", 32'(rx_pol_inv), 32'd0);
`endif
    endtask

    logic [127:0] ts1_a, ts2_a, bad_set, ts1_b, inv_set;

    initial begin
        ts1_a   = mk(8'hBC, 8'hF7, 8'hF7, 6'h02, 8'h4A);
        ts2_a   = mk(8'hBC, 8'hF7, 8'hF7, 6'h02, 8'h45);
        bad_set = mk(8'h00, 8'hF7, 8'hF7, 6'h02, 8'h4A);
        ts1_b   = mk(8'hBC, 8'h01, 8'h00, 6'h06, 8'h4A);
        inv_set = mk(8'hBC, 8'h22, 8'h03, 6'h0A, 8'hB5);
        fif.rx_fifo_data  = '0;
        fif.rx_fifo_empty = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_cnt", 32'(rx_cnt), 32'd0);
        chk("reset_outs", {rx_link_num, rx_lane_num, 2'b00, rx_rate, 4'd0, ts1_rcvd_enough, ts2_rcvd_enough, rx_err, rx_pol_inv}, 32'd0);
        chk("reset_rd", 32'(fif.rx_fifo_rd), 32'd0);
        rst = 1'b0;
        rx_en = 1'b1;
        repeat (2) @(negedge clk);

        // 8 identical TS1 reach the target of 8
        for (int i = 1; i <= 8; i++) send(ts1_a, i, i == 8, 1'b0, 1'b0, 8'hF7, 6'h02, 1'b0);
        drain();
        chk("lane_num", 32'(rx_lane_num), 32'hF7);
        do_clear();

        // Type change restarts the count
        for (int i = 1; i <= 5; i++) send(ts1_a, i, 1'b0, 1'b0, 1'b0, 8'hF7, 6'h02, 1'b0);
        send(ts2_a, 1, 1'b0, 1'b0, 1'b0, 8'hF7, 6'h02, 1'b0);
        for (int j = 1; j <= 8; j++) send(ts2_a, j + 1, 1'b0, j >= 7, 1'b0, 8'hF7, 6'h02, 1'b0);
        drain();
        do_clear();

        // Malformed set in the middle of a run
        for (int i = 1; i <= 4; i++) send(ts1_a, i, 1'b0, 1'b0, 1'b0, 8'hF7, 6'h02, 1'b0);
        send(bad_set, 0, 1'b0, 1'b0, 1'b1, 8'hF7, 6'h02, 1'b0);
        for (int i = 1; i <= 8; i++) send(ts1_b, i, i == 8, 1'b0, 1'b0, 8'h01, 6'h06, 1'b0);
        drain();
        do_clear();

        // FIFO empty toggling every other cycle
        toggle_mode = 1'b1;
        for (int i = 1; i <= 6; i++) send(ts2_a, i, 1'b0, 1'b0, 1'b0, 8'hF7, 6'h02, 1'b0);
        drain();
        toggle_mode = 1'b0;
        stall = 1'b0;
        chk("toggle_cnt", 32'(rx_cnt), 32'd6);
        do_clear();

        // Target of 1 and 0
        rx_target = 16'd1;
        send(ts2_a, 1, 1'b0, 1'b1, 1'b0, 8'hF7, 6'h02, 1'b0);
        send(ts2_a, 2, 1'b0, 1'b1, 1'b0, 8'hF7, 6'h02, 1'b0);
        drain();
        do_clear();
        rx_target = 16'd0;
        send(ts1_b, 1, 1'b1, 1'b0, 1'b0, 8'h01, 6'h06, 1'b0);
        drain();
        do_clear();
        rx_target = 16'd8;

        // Inverted-polarity identifier
`ifdef TS_RX_POLARITY_DET_EN
        for (int i = 1; i <= 8; i++) send(inv_set, i, i == 8, 1'b0, 1'b0, 8'h22, 6'h0A, 1'b1);
`else
        for (int i = 1; i <= 8; i++) send(inv_set, 0, 1'b0, 1'b0, 1'b1, 8'h01, 6'h06, 1'b0);
`endif
        drain();
        do_clear();

        // Disable clears flags and count and stops reads
        rx_target = 16'd2;
        for (int i = 1; i <= 3; i++) send(ts1_a, i, i >= 2, 1'b0, 1'b0, 8'hF7, 6'h02, 1'b0);
        drain();
        rx_en = 1'b0;
        @(negedge clk);
        chk("dis_cnt", 32'(rx_cnt), 32'd0);
        chk("dis_flags", {30'd0, ts1_rcvd_enough, ts2_rcvd_enough}, 32'd0);
        send(ts1_b, 1, 1'b0, 1'b0, 1'b0, 8'h01, 6'h06, 1'b0);
        repeat (5) @(negedge clk);
        chk("dis_no_rd", 32'(fifo_q.size()), 32'd1);
        rx_en = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ts_rx_chk.md
Name: ts_rx_chk

Overview:
- Receive-side counterpart of the TS1/TS2 ordered-set generator.
- Pops 128-bit ordered sets from the RX FIFO and validates COM and identifier symbols.
- Counts consecutive identical TS1/TS2 sets and flags the LTSSM when the required number has been received.
- Latches received link number, lane number and rate support for state-transition decisions.

Parameters:
- CNT_W, 16: width of the consecutive-TS counter and the target input.
- SAT_EN_DEFAULT, 1: counter saturates at all-ones instead of wrapping.

Ports:
- clk  in  1  1GHz system clock
- rst  in  1  synchronous, active-high reset
- rx_en  in  1  checker enable from LTSSM; 0 forces IDLE
- rx_clear  in  1  one-cycle pulse: clear count/flags, return to HUNT
- rx_target  in  CNT_W  consecutive-set threshold (e.g. 8 for Polling.Active exit)
- rx_fifo_empty  in  1  RX FIFO empty
- rx_fifo_rd  out  1  FIFO pop request
- rx_fifo_data  in  128  ordered set; symbol0 in [127:120], symbol15 in [7:0]
- ts1_rcvd_enough  out  1  target consecutive TS1 reached (sticky)
- ts2_rcvd_enough  out  1  target consecutive TS2 reached (sticky)
- rx_cnt  out  CNT_W  current consecutive count
- rx_link_num  out  8  symbol1 of last accepted set
- rx_lane_num  out  8  symbol2 of last accepted set
- rx_rate  out  6  symbol4[5:0] of last accepted set
- rx_err  out  1  one-cycle pulse on malformed set

Behaviour:
- Reset: all outputs 0, state IDLE, stored reference set cleared.
- FIFO handshake:
  - rx_fifo_rd = rx_en & ~rx_fifo_empty & state!=IDLE.
  - Read latency 1: data valid the cycle after rd; internal rd_d tracks this.
  - Data arriving while rx_en has just dropped is discarded.
- Set classification (symbol0 must be COM 8'hBC):
  - TS1 if symbols 6..15 all equal D10.2 (8'h4A).
  - TS2 if symbols 6..15 all equal D5.2 (8'h45).
  - Anything else is malformed: rx_err pulses, count -> 0, state -> HUNT.
- "Identical" means same type and equal symbols 1..5 as the stored reference set.
- States:
  - IDLE: no reads; rx_en=1 -> HUNT.
  - HUNT: first valid set stores the reference, count=1 -> TRACK.
  - TRACK:
    - Identical set -> count+1.
    - Valid but different set -> becomes the new reference, count=1.
    - When count reaches rx_target, set the ts1/ts2 flag matching the type -> DONE.
  - DONE: keeps reading and updating fields; the count keeps running or saturating; the flag holds until clear.
- Timing: flags, count and fields update on the edge after data is valid, i.e. 2 cycles after rd.
- rx_target=0: the first valid set sets the flag.
- rx_target=1: the HUNT set itself sets the flag; go straight to DONE.
- Counter at all-ones saturates (SAT_EN_DEFAULT=1) or wraps to 0 (0).
- Priority: rst > rx_en=0 (-> IDLE, clears count and flags) > rx_clear (-> HUNT, clears count and flags, drops same-cycle data) > data.
- rx_link_num, rx_lane_num and rx_rate update on every valid set, including HUNT.

Optional Feature:
- Macro: TS_RX_POLARITY_DET_EN.
- When defined:
  - Identifiers D21.5 (8'hB5) and D26.5 (8'hBA) are accepted as inverted-polarity TS1 and TS2.
  - Output rx_pol_inv (1 bit, reset 0) is set sticky on the first inverted set; cleared by rx_clear, rx_en=0 and rst.
  - Inverted sets count as TS1/TS2.
- When undefined: the rx_pol_inv port is absent and those identifiers are malformed.

Decomposition:
- Shared package/define file:
  - COM, PADG12, D10_2, D5_2, D21_5, D26_5 symbol constants.
  - TS type encoding (NONE/TS1/TS2).
  - State encodings IDLE/HUNT/TRACK/DONE.
- Sub-module ts_rx_decode: purely combinational classifier. Takes 128 bits and returns type, malformed and inverted, plus the split fields.

Test Plan:
- 8 TS1 (link F7, lane F7, rate 6'h02), rx_target=8 -> ts1_rcvd_enough rises 2 cycles after the 8th rd; rx_cnt=8; rx_rate=2.
- 5 TS1, 1 TS2, then 8 TS2, target 8 -> count resets to 1 on the TS2 change; ts2 flag set after the 8th TS2; ts1 flag never set.
- 4 TS1, one set with symbol0=8'h00, then 8 TS1 -> rx_err single-cycle pulse; count restarts; flag after 8 more.
- rx_fifo_empty toggling every other cycle -> rd only when not empty; count equals number of sets popped; no double counting.
- Flag set, then rx_clear -> flag 0 and count 0 next cycle; next set gives count=1.
- With TS_RX_POLARITY_DET_EN: 8 sets using 8'hB5 -> rx_pol_inv=1 and ts1_rcvd_enough=1. Without the macro -> 8 rx_err pulses and no flag.
